// File: rtl/scale_line_writer.sv
// Packs scaled pixels into 128-bit words, buffers them in a 128-deep FIFO and
// writes each completed destination row to DDR as one burst.
module scale_line_writer #(
    parameter int unsigned PIX_WIDTH   = 16,
    parameter int unsigned LINE_PIX    = 640,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LINE_STRIDE = 1280
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_WIDTH-1:0] pix_data,
    input  logic                 pix_vaild,
    input  logic [10:0]          dst_row,
    output logic                 wr_burst_req,
    output logic [31:0]          wr_burst_addr,
    output logic [7:0]           wr_burst_len,
    input  logic                 wr_burst_data_req,
    output logic [127:0]         wr_burst_data,
    input  logic                 wr_burst_finish,
    output logic                 line_done,
    output logic                 overflow
);

    localparam int unsigned WORD_W     = 128;
    localparam int unsigned SLOT_W     = WORD_W / 8;
    localparam int unsigned FIFO_DEPTH = 128;
    localparam int unsigned ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W      = ADDR_W + 1;
    localparam int unsigned PIX_CNT_W  = $clog2(LINE_PIX);
    localparam int unsigned ROW_W      = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic [2:0]           pack_cnt;
    logic [WORD_W-1:0]    pack_buf;
    logic [WORD_W-1:0]    pack_next;
    logic [WORD_W-1:0]    word_reg;
    logic                 word_vld;
    logic [ROW_W-1:0]     row_lat;
    logic [ROW_W-1:0]     rq0;
    logic [ROW_W-1:0]     rq1;
    logic [1:0]           pending;
    logic [WORD_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_we;
    logic        rd_pop;
    logic        pix_acc;
    logic        pix_last;
    logic        row_push;
    logic        row_pop;
    logic [31:0] addr_calc;

    assign wr_burst_len = 8'(LINE_PIX / 8);

    assign fifo_full  = (wr_ptr - rd_ptr) == PTR_W'(FIFO_DEPTH);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_we    = word_vld && !fifo_full;
    assign rd_pop     = wr_burst_data_req && ((state == REQ) || (state == DATA)) && !fifo_empty;

    // Pixels are refused while two finished rows still wait for the DDR port.
    assign pix_acc  = pix_vaild && (pending != 2'd2);
    assign pix_last = (pix_cnt == PIX_CNT_W'(LINE_PIX - 1));
    assign row_push = pix_acc && pix_last;
    assign row_pop  = (state == DONE);

    assign addr_calc = BASE_ADDR + (32'(rq0) - 32'd1) * 32'(LINE_STRIDE);

    always_comb begin
        pack_next = pack_buf;
        pack_next[{pack_cnt, 4'b0000} +: SLOT_W] = SLOT_W'(pix_data);
    end

    // Pixel counter, packer and row bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt  <= '0;
            pack_cnt <= '0;
            pack_buf <= '0;
            word_reg <= '0;
            word_vld <= 1'b0;
            row_lat  <= '0;
        end else begin
            word_vld <= 1'b0;
            if (pix_vaild) begin
                pix_cnt <= pix_last ? '0 : pix_cnt + PIX_CNT_W'(1);
                if (pix_cnt == '0) begin
                    row_lat <= dst_row;
                end
            end
            if (pix_acc) begin
                pack_buf <= pack_next;
                pack_cnt <= pack_cnt + 3'd1;
                if (pack_cnt == 3'd7) begin
                    word_reg <= pack_next;
                    word_vld <= 1'b1;
                end
            end
        end
    end

    // Pending-line count and two-entry row queue (rq0 is the head).
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            rq0     <= '0;
            rq1     <= '0;
        end else begin
            pending <= pending + {1'b0, row_push} - {1'b0, row_pop};
            if (row_push && row_pop) begin
                if (pending == 2'd1) begin
                    rq0 <= row_lat;
                end else begin
                    rq0 <= rq1;
                    rq1 <= row_lat;
                end
            end else if (row_push) begin
                if (pending == 2'd0) begin
                    rq0 <= row_lat;
                end else begin
                    rq1 <= row_lat;
                end
            end else if (row_pop) begin
                rq0 <= rq1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_we) begin
            mem[wr_ptr[ADDR_W-1:0]] <= word_reg;
        end
    end

    // FIFO pointers, registered read port and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wr_burst_data <= '0;
            overflow      <= 1'b0;
        end else begin
            if (fifo_we) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if ((word_vld && fifo_full) || (pix_vaild && !pix_acc)) begin
                overflow <= 1'b1;
            end
            if (rd_pop) begin
                wr_burst_data <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Burst write FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_burst_req  <= 1'b0;
            wr_burst_addr <= '0;
            line_done     <= 1'b0;
        end else begin
            line_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending != 2'd0) begin
                        wr_burst_addr <= addr_calc;
                        wr_burst_req  <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (wr_burst_data_req) begin
                        wr_burst_req <= 1'b0;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (wr_burst_finish) begin
                        line_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scale_line_writer.sv
// Randomized self-checking bench for scale_line_writer with a queue-based
// model of pixel packing, row bookkeeping and burst addressing.
module tb_scale_line_writer;

    localparam int unsigned LINE_PIX    = 640;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam int unsigned LINE_STRIDE = 1280;
    localparam int unsigned WORDS       = LINE_PIX / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  pix_data;
    logic         pix_vaild;
    logic [10:0]  dst_row;
    logic         wr_burst_req;
    logic [31:0]  wr_burst_addr;
    logic [7:0]   wr_burst_len;
    logic         wr_burst_data_req;
    logic [127:0] wr_burst_data;
    logic         wr_burst_finish;
    logic         line_done;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [127:0] exp_words[$];
    int           model_rows[$];
    logic [15:0]  acc[8];
    int           acc_n;
    int           model_pending;
    bit           model_ovf;
    logic [127:0] last_word;
    logic [127:0] first_data;

    scale_line_writer #(
        .PIX_WIDTH  (16),
        .LINE_PIX   (LINE_PIX),
        .BASE_ADDR  (BASE_ADDR),
        .LINE_STRIDE(LINE_STRIDE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pix_data         (pix_data),
        .pix_vaild        (pix_vaild),
        .dst_row          (dst_row),
        .wr_burst_req     (wr_burst_req),
        .wr_burst_addr    (wr_burst_addr),
        .wr_burst_len     (wr_burst_len),
        .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data    (wr_burst_data),
        .wr_burst_finish  (wr_burst_finish),
        .line_done        (line_done),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] row_addr(input int row);
        longint a;
        a = longint'(BASE_ADDR) + (longint'(row) - 1) * longint'(LINE_STRIDE);
        return 32'(a);
    endfunction

    task automatic model_clear();
        exp_words.delete();
        model_rows.delete();
        acc_n         = 0;
        model_pending = 0;
        model_ovf     = 1'b0;
        last_word     = '0;
    endtask

    task automatic model_pixel(input logic [15:0] d, input int p, input int row);
        logic [127:0] w;
        if (model_pending == 2) begin
            model_ovf = 1'b1;
        end else begin
            acc[acc_n] = d;
            acc_n++;
            if (acc_n == 8) begin
                w = '0;
                for (int j = 0; j < 8; j++) w[j*16 +: 16] = acc[j];
                if (exp_words.size() >= 128) model_ovf = 1'b1;
                else exp_words.push_back(w);
                acc_n = 0;
            end
            if (p == LINE_PIX - 1) begin
                model_pending++;
                model_rows.push_back(row);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic feed_row(input int row, input bit gaps, input bit ramp);
        int p = 0;
        while (p < LINE_PIX) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                pix_vaild = 1'b0;
                pix_data  = 16'($urandom);
            end else begin
                pix_vaild = 1'b1;
                pix_data  = ramp ? 16'(p) : 16'($urandom);
                dst_row   = 11'(row);
                model_pixel(pix_data, p, row);
                p++;
            end
        end
        @(negedge clk);
        pix_vaild = 1'b0;
    endtask

    task automatic run_burst(input int n_pop, input bit finish_it);
        int           waited = 0;
        int           row;
        bit           got;
        logic [127:0] exp_w = '0;
        while (!wr_burst_req && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!wr_burst_req) begin
            errors++;
            $display("FAIL burst_req_timeout: wr_burst_req=%0b expected 1", wr_burst_req);
            return;
        end
        row = (model_rows.size() > 0) ? model_rows[0] : 0;
        checks++;
        if (wr_burst_addr !== row_addr(row)) begin
            errors++;
            $display("FAIL burst_addr row %0d: got %h expected %h", row, wr_burst_addr, row_addr(row));
        end
        checks++;
        if (wr_burst_len !== 8'(WORDS)) begin
            errors++;
            $display("FAIL burst_len: got %0d expected %0d", wr_burst_len, WORDS);
        end
        for (int i = 0; i <= n_pop; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (i == 1) first_data = wr_burst_data;
                checks++;
                if (wr_burst_data !== exp_w) begin
                    errors++;
                    $display("FAIL burst_word %0d: got %h expected %h", i - 1, wr_burst_data, exp_w);
                end
            end
            if (i == 1) begin
                checks++;
                if (wr_burst_req !== 1'b0) begin
                    errors++;
                    $display("FAIL req_drop: wr_burst_req=%0b expected 0", wr_burst_req);
                end
            end
            if (i < n_pop) begin
                wr_burst_data_req = 1'b1;
                if (exp_words.size() > 0) last_word = exp_words.pop_front();
                exp_w = last_word;
            end else begin
                wr_burst_data_req = 1'b0;
            end
        end
        if (finish_it) begin
            wr_burst_finish = 1'b1;
            @(negedge clk);
            wr_burst_finish = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                if (line_done === 1'b1) got = 1'b1;
                else @(negedge clk);
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL line_done: not seen, expected pulse");
            end
            @(negedge clk);
            checks++;
            if (line_done !== 1'b0) begin
                errors++;
                $display("FAIL line_done_pulse: got %0b expected 0", line_done);
            end
            model_pending--;
            if (model_rows.size() > 0) void'(model_rows.pop_front());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (wr_burst_req !== 1'b0 || wr_burst_addr !== 32'h0 || wr_burst_data !== 128'h0 ||
            line_done !== 1'b0 || overflow !== 1'b0 || wr_burst_len !== 8'(WORDS)) begin
            errors++;
            $display("FAIL %s: req=%0b addr=%h data=%h done=%0b ovf=%0b len=%0d expected 0/0/0/0/0/%0d",
                     tag, wr_burst_req, wr_burst_addr, wr_burst_data, line_done, overflow,
                     wr_burst_len, WORDS);
        end
    endtask

    task automatic check_ovf(input string tag);
        checks++;
        if (overflow !== model_ovf) begin
            errors++;
            $display("FAIL %s: overflow=%0b expected %0b", tag, overflow, model_ovf);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset_values");
    endtask

    task automatic test_single_row();
        do_reset();
        feed_row(1, 1'b0, 1'b1);
        run_burst(WORDS, 1'b1);
        checks++;
        if (first_data !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
            errors++;
            $display("FAIL word0_ramp: got %h expected 00070006000500040003000200010000", first_data);
        end
        check_ovf("single_row_ovf");
    endtask

    task automatic test_back_to_back();
        int idle_req = 0;
        do_reset();
        feed_row(359, 1'b0, 1'b0);
        feed_row(360, 1'b0, 1'b0);
        feed_row(361, 1'b0, 1'b0);
        check_ovf("stall_ovf");
        run_burst(WORDS, 1'b1);
        run_burst(WORDS, 1'b1);
        repeat (20) begin
            @(negedge clk);
            if (wr_burst_req) idle_req++;
        end
        checks++;
        if (idle_req != 0) begin
            errors++;
            $display("FAIL dropped_row_burst: req cycles=%0d expected 0", idle_req);
        end
        check_ovf("stall_ovf_sticky");
    endtask

    task automatic test_idle_ignore();
        do_reset();
        @(negedge clk);
        wr_burst_finish = 1'b1;
        @(negedge clk);
        wr_burst_finish   = 1'b0;
        wr_burst_data_req = 1'b1;
        @(negedge clk);
        wr_burst_data_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_ignore");
        feed_row(5, 1'b0, 1'b1);
        run_burst(WORDS, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        feed_row($urandom_range(1, 2047), 1'b0, 1'b0);
        run_burst(40, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_burst_reset");
        rst = 1'b0;
        model_clear();
        repeat (5) @(negedge clk);
        checks++;
        if (wr_burst_req !== 1'b0) begin
            errors++;
            $display("FAIL no_reissue: wr_burst_req=%0b expected 0", wr_burst_req);
        end
        feed_row($urandom_range(1, 2047), 1'b0, 1'b0);
        run_burst(WORDS, 1'b1);
    endtask

    task automatic test_random_gaps();
        do_reset();
        feed_row($urandom_range(1, 2047), 1'b1, 1'b0);
        run_burst(WORDS, 1'b1);
        check_ovf("gaps_ovf");
    endtask

    initial begin
        rst               = 1'b1;
        pix_data          = '0;
        pix_vaild         = 1'b0;
        dst_row           = '0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        model_clear();
        test_reset();
        test_single_row();
        test_back_to_back();
        test_idle_ignore();
        test_reset_mid_burst();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
